bicubic_tap_mac: RTL and testbench

- Four-tap weighted-sum stage that consumes the bicubic weights produced by the BiCubic weight generators.
- Multiplies a column of four pixels by their signed Q1.8 weights, sums the products, rounds, clamps to 8 bits, and emits the result through a valid/ready stream.
- Sits between the weight generators / 4x4 window buffer and the horizontal pass.
- Two instances are cascaded (vertical, then horizontal) to form a full bicubic output pixel.

---
 rtl/bicubic_pkg.sv | 13 +
 rtl/bicubic_round_clamp.sv | 33 +++
 rtl/bicubic_tap_mac.sv | 94 +++++++++
 tb/tb_bicubic_tap_mac.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants and arithmetic types for the bicubic tap MAC and its round/clamp stage.
package bicubic_pkg;
  localparam int DATA_W = 8;
  localparam int COEF_W = 9;
  localparam int FRAC_W = 8;
  localparam int ONE    = 256;
  localparam int SUM_W  = 20;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int PSUM_W = PROD_W + 2;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
endpackage

// File: rtl/bicubic_round_clamp.sv
// Combinational round/shift/clamp of a signed Q.FRAC_W weighted sum to an unsigned pixel.
// BICUBIC_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.
module bicubic_round_clamp #(
  parameter int DATA_W = bicubic_pkg::DATA_W,
  parameter int FRAC_W = bicubic_pkg::FRAC_W
) (
  input  logic signed [bicubic_pkg::SUM_W-1:0] i_sum,
  output logic        [DATA_W-1:0]             o_pix
);
  import bicubic_pkg::*;

  function automatic sum_t round_sum(input sum_t s);
`ifdef BICUBIC_ROUND_EN
    return s + sum_t'(1 << (FRAC_W - 1));
`else
    return s;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] clamp_pix(input sum_t r);
    if (r < 0)
      return '0;
    else if (r > sum_t'((1 << DATA_W) - 1))
      return '1;
    else
      return r[DATA_W-1:0];
  endfunction

  sum_t w_shift;

  assign w_shift = round_sum(i_sum) >>> FRAC_W;
  assign o_pix   = clamp_pix(w_shift);
endmodule

// File: rtl/bicubic_tap_mac.sv
// Four-tap signed-weight MAC with a globally-stalled valid/ready pipeline feeding round/clamp.
// Rounding mode set by BICUBIC_ROUND_EN (see bicubic_round_clamp).
module bicubic_tap_mac #(
  parameter int DATA_W = bicubic_pkg::DATA_W,
  parameter int COEF_W = bicubic_pkg::COEF_W,
  parameter int FRAC_W = bicubic_pkg::FRAC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] in_pix,
  input  logic [4*COEF_W-1:0] in_w,
  input  logic [3:0]          in_wneg,
  input  logic                in_sof,
  input  logic                in_eol,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_pix,
  output logic                out_sof,
  output logic                out_eol
);
  import bicubic_pkg::*;

  localparam int PW = DATA_W + COEF_W;

  function automatic psum_t signed_term(input logic [PW-1:0] p, input logic neg);
    psum_t t;
    t = psum_t'({2'b00, p});
    return neg ? -t : t;
  endfunction

  logic              w_en;
  logic              r_vld_p0, r_vld_p1, r_vld_p2;
  logic [PW-1:0]     r_prod_p0 [4];
  logic [3:0]        r_neg_p0;
  logic              r_sof_p0, r_sof_p1, r_sof_p2;
  logic              r_eol_p0, r_eol_p1, r_eol_p2;
  psum_t             r_psa_p1, r_psb_p1;
  sum_t              r_sum_p2;
  logic [DATA_W-1:0] w_pix;

  // One advance for the whole pipe: it only freezes when a result is stuck at the output.
  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (w_en) begin
      r_vld_p0  <= in_valid;
      r_vld_p1  <= r_vld_p0;
      r_vld_p2  <= r_vld_p1;
      out_valid <= r_vld_p2;
      out_pix   <= w_pix;
      out_sof   <= r_vld_p2 & r_sof_p2;
      out_eol   <= r_vld_p2 & r_eol_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      // S1: unsigned tap products
      for (int i = 0; i < 4; i++)
        r_prod_p0[i] <= PW'(in_pix[i*DATA_W +: DATA_W]) * PW'(in_w[i*COEF_W +: COEF_W]);
      r_neg_p0 <= in_wneg;
      r_sof_p0 <= in_sof;
      r_eol_p0 <= in_eol;
      // S2: signed pair sums
      r_psa_p1 <= signed_term(r_prod_p0[0], r_neg_p0[0]) + signed_term(r_prod_p0[1], r_neg_p0[1]);
      r_psb_p1 <= signed_term(r_prod_p0[2], r_neg_p0[2]) + signed_term(r_prod_p0[3], r_neg_p0[3]);
      r_sof_p1 <= r_sof_p0;
      r_eol_p1 <= r_eol_p0;
      // S3: full signed total, rounded/clamped on its way into the output register
      r_sum_p2 <= sum_t'(r_psa_p1) + sum_t'(r_psb_p1);
      r_sof_p2 <= r_sof_p1;
      r_eol_p2 <= r_eol_p1;
    end
  end

  bicubic_round_clamp #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_clamp (
    .i_sum (r_sum_p2),
    .o_pix (w_pix)
  );
endmodule

// File: tb/tb_bicubic_tap_mac.sv
// Directed and randomized bench for bicubic_tap_mac against an arithmetic reference model.
module tb_bicubic_tap_mac;
`ifdef BICUBIC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pix;
  logic [35:0] in_w;
  logic [3:0]  in_wneg;
  logic        in_sof, in_eol;
  logic        out_valid, out_ready;
  logic [7:0]  out_pix;
  logic        out_sof, out_eol;

  always #5 clk = ~clk;

  bicubic_tap_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_w      (in_w),
    .in_wneg   (in_wneg),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         outs   = 0;
  bit         acc;
  bit         held_f = 1'b0;
  logic [7:0] held_pix;
  logic       held_sof, held_eol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Weighted sum with signed weights, then round/truncate by 256 (floor) and clamp to 0..255.
  function automatic logic [7:0] ref_pix(input logic [31:0] p, input logic [35:0] w, input logic [3:0] neg);
    int s;
    int term;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      term = int'(p[8*i +: 8]) * int'(w[9*i +: 9]);
      s = neg[i] ? s - term : s + term;
    end
    if (ROUND) s = s + 128;
    s = s >>> 8;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  task automatic sample();
    if (out_valid) begin
      if (held_f) begin
        chk("hold_pix", 32'(out_pix), 32'(held_pix));
        chk("hold_sof", 32'(out_sof), 32'(held_sof));
        chk("hold_eol", 32'(out_eol), 32'(held_eol));
      end
      if (out_ready) begin
        chk("out_has_beat", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          chk("sb_pix", 32'(out_pix), 32'(sb[0].pix));
          chk("sb_sof", 32'(out_sof), 32'(sb[0].sof));
          chk("sb_eol", 32'(out_eol), 32'(sb[0].eol));
          void'(sb.pop_front());
        end
        held_f = 1'b0;
        outs++;
      end else begin
        held_f   = 1'b1;
        held_pix = out_pix;
        held_sof = out_sof;
        held_eol = out_eol;
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back('{pix: ref_pix(in_pix, in_w, in_wneg), sof: in_sof, eol: in_eol});
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] p, input logic [35:0] w,
                         input logic [3:0] neg, input logic [7:0] expv);
    int lat;
    in_pix = p; in_w = w; in_wneg = neg; in_sof = 1'b0; in_eol = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_pix"}, 32'(out_pix), 32'(expv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int i, guard, nacc;
    rst_n = 1'b0; in_valid = 1'b0; in_pix = '0; in_w = '0; in_wneg = '0;
    in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pix", 32'(out_pix), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_eol", 32'(out_eol), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    run_one("identity", {8'd40, 8'd30, 8'd20, 8'd10}, {9'd0, 9'd0, 9'd256, 9'd0}, 4'b0000, 8'd20);
    run_one("undershoot", {8'd255, 8'd0, 8'd0, 8'd255}, {9'd32, 9'd160, 9'd160, 9'd32}, 4'b1001, 8'd0);
    run_one("overshoot", {8'd0, 8'd255, 8'd255, 8'd0}, {9'd32, 9'd160, 9'd160, 9'd32}, 4'b1001, 8'd255);
    run_one("round_pos", {8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'd128}, 4'b0000, ROUND ? 8'd1 : 8'd0);
    run_one("round_neg", {8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'd128}, 4'b0001, 8'd0);
    run_one("full_scale", {4{8'd255}}, {4{9'd511}}, 4'b0000, 8'd255);
    run_one("full_neg", {4{8'd255}}, {4{9'd511}}, 4'b1111, 8'd0);
    run_one("mixed", {8'd0, 8'd0, 8'd200, 8'd100}, {9'd0, 9'd0, 9'd64, 9'd384}, 4'b0010, ROUND ? 8'd100 : 8'd100);

    // Back-pressure: p1 = 1..8 with unit weight on tap 1, eol on the last beat.
    i = 0; guard = 0; outs = 0;
    while (i < 8 && guard < 400) begin
      in_pix = {8'd0, 8'd0, 8'(i + 1), 8'd0};
      in_w = {9'd0, 9'd0, 9'd256, 9'd0};
      in_wneg = 4'b0000; in_sof = (i == 0); in_eol = (i == 7);
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("bp_accepted", 32'(i), 32'd8);
    chk("bp_outputs", 32'(outs), 32'd8);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Random beats, random valid gaps and random back-pressure.
    nacc = 0; outs = 0; guard = 0;
    while (nacc < 60 && guard < 2000) begin
      for (int j = 0; j < 4; j++) begin
        in_pix[8*j +: 8] = 8'($urandom_range(0, 255));
        in_w[9*j +: 9]   = 9'($urandom_range(0, 511));
      end
      in_wneg = 4'($urandom_range(0, 15));
      in_sof = 1'($urandom_range(0, 1));
      in_eol = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
      if (acc) nacc++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("rnd_accepted", 32'(nacc), 32'd60);
    chk("rnd_outputs", 32'(outs), 32'(nacc));
    chk("rnd_drained", 32'(sb.size()), 32'd0);

    // Reset with the pipeline full and a result waiting at the output.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pix = {8'd0, 8'd0, 8'(50 + k), 8'd0};
      in_w = {9'd0, 9'd0, 9'd256, 9'd0};
      in_wneg = 4'b0000; in_sof = 1'b0; in_eol = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_pix", 32'(out_pix), 32'd0);
    sb.delete();
    held_f = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one("post_rst_first", {8'd0, 8'd0, 8'd77, 8'd0}, {9'd0, 9'd0, 9'd256, 9'd0}, 4'b0000, 8'd77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
